// File: rtl/mimosa_clock_sequencer.sv
// mimosa_clock_sequencer: gated, divided model clock under RUN/STEP/BURST/HALT control.
// Ports: clk, rst_n | cmd_valid/cmd_ready/cmd_op/cmd_count, abort | model_clk, tick, done,
//        state, remaining, tick_total. Define MIMOSA_SEQ_TICK_COUNTER_EN to build tick_total.
module mimosa_clock_sequencer #(
  parameter int unsigned PRESCALER = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_count,
  input  logic        abort,
  output logic        model_clk,
  output logic        tick,
  output logic        done,
  output logic [1:0]  state,
  output logic [15:0] remaining,
  output logic [31:0] tick_total
);

  localparam int unsigned CW = $clog2(PRESCALER);
  localparam logic [CW-1:0] LAST = CW'(PRESCALER - 1);
  localparam logic [CW-1:0] FALL = CW'(PRESCALER / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_COUNT = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t        st_q;
  state_t        st_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clk_d;
  logic          tick_d;
  logic          done_d;
  logic [15:0]   rem_d;

  logic wrap;
  logic fall;
  logic due;
  logic accept;
  logic op_halt;
  logic op_run;
  logic op_step;
  logic op_burst;

  assign op_halt  = cmd_op == 2'b00;
  assign op_run   = cmd_op == 2'b01;
  assign op_step  = cmd_op == 2'b10;
  assign op_burst = cmd_op == 2'b11;

  assign cmd_ready = !abort && (st_q == S_IDLE || st_q == S_RUN);
  assign accept    = cmd_valid && cmd_ready;

  assign wrap = cnt_q == LAST;
  assign fall = cnt_q == FALL;
  // DRAIN keeps the phase counter running but never starts a new period.
  assign due  = wrap && (st_q == S_RUN || st_q == S_COUNT);

  assign state = st_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    clk_d  = model_clk;
    tick_d = 1'b0;
    done_d = 1'b0;
    rem_d  = remaining;

    if (st_q != S_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (fall) clk_d = 1'b0;
      if (due) begin
        clk_d  = 1'b1;
        tick_d = 1'b1;
      end
    end

    unique case (st_q)
      S_IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (accept) begin
          unique case (1'b1)
            op_run: st_d = S_RUN;
            op_step: begin
              st_d  = S_COUNT;
              rem_d = 16'd1;
            end
            op_burst: begin
              if (cmd_count != '0) begin
                st_d  = S_COUNT;
                rem_d = cmd_count;
              end else begin
                done_d = 1'b1;
              end
            end
            op_halt: st_d = S_IDLE;
            default: st_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (abort || (accept && op_halt)) begin
          st_d  = S_DRAIN;
          rem_d = '0;
        end
      end
      S_COUNT: begin
        if (abort) begin
          st_d  = S_DRAIN;
          rem_d = '0;
        end else if (due) begin
          rem_d = remaining - 16'd1;
          if (remaining == 16'd1) st_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave only once the high phase has fully completed.
        if (!model_clk) begin
          st_d   = S_IDLE;
          cnt_d  = '0;
          clk_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      model_clk <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      model_clk <= clk_d;
      tick      <= tick_d;
      done      <= done_d;
      remaining <= rem_d;
    end
  end

`ifdef MIMOSA_SEQ_TICK_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_total <= '0;
    end else if (tick_d && tick_total != '1) begin
      tick_total <= tick_total + 32'd1;
    end
  end
`else
  assign tick_total = '0;
`endif

endmodule

// File: tb/tb_mimosa_clock_sequencer.sv
// tb_mimosa_clock_sequencer: vector table, corner sequences and random run
// against a reference model of the sequencer, PRESCALER=8.
module tb_mimosa_clock_sequencer;

  localparam int P = 8;
  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_BURST = 2'b11;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_COUNT = 2;
  localparam int M_DRAIN = 3;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count;
  logic        abort;
  logic        model_clk;
  logic        tick;
  logic        done;
  logic [1:0]  state;
  logic [15:0] remaining;
  logic [31:0] tick_total;

  mimosa_clock_sequencer #(.PRESCALER(P)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_count(cmd_count),
    .abort(abort),
    .model_clk(model_clk),
    .tick(tick),
    .done(done),
    .state(state),
    .remaining(remaining),
    .tick_total(tick_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: elapsed cycles since acceptance drive the period
  // arithmetic; a rise happens every P cycles while ticking is allowed.
  int          m_st;
  int          m_age;
  int          m_last;
  bit          m_seen;
  bit          m_clk;
  bit          m_tick;
  bit          m_done;
  int          m_rem;
  logic [31:0] m_total;
  logic        rdy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = M_IDLE;
    m_age = 0;
    m_last = 0;
    m_seen = 0;
    m_clk = 0;
    m_tick = 0;
    m_done = 0;
    m_rem = 0;
    m_total = 0;
  endtask

  function automatic bit m_ready(input logic ab);
    return !ab && (m_st == M_IDLE || m_st == M_RUN);
  endfunction

  task automatic model_edge(input logic v, input logic [1:0] op,
                            input logic [15:0] n, input logic ab);
    bit acc;
    bit due;
    acc = v && m_ready(ab);
    m_tick = 0;
    m_done = 0;
    if (m_st != M_IDLE) m_age++;
    due = (m_st == M_RUN || m_st == M_COUNT) && (m_age % P == 0);
    case (m_st)
      M_IDLE: if (acc) begin
        if (op == OP_RUN) begin
          m_st = M_RUN; m_age = 0; m_seen = 0;
        end else if (op == OP_STEP) begin
          m_st = M_COUNT; m_age = 0; m_seen = 0; m_rem = 1;
        end else if (op == OP_BURST) begin
          if (n != 0) begin
            m_st = M_COUNT; m_age = 0; m_seen = 0; m_rem = int'(n);
          end else m_done = 1;
        end
      end
      M_RUN: if (ab || (acc && op == OP_HALT)) m_st = M_DRAIN;
      M_COUNT: begin
        if (ab) begin
          m_st = M_DRAIN; m_rem = 0;
        end else if (due) begin
          m_rem--;
          if (m_rem == 0) m_st = M_DRAIN;
        end
      end
      M_DRAIN: if (!m_clk) begin
        m_st = M_IDLE; m_done = 1;
      end
      default: m_st = M_IDLE;
    endcase
    if (due) begin
      m_tick = 1;
      m_last = m_age;
      m_seen = 1;
      if (m_total != 32'hFFFF_FFFF) m_total++;
    end
    m_clk = (m_st != M_IDLE) && m_seen && (m_age - m_last < P / 2);
  endtask

  task automatic check_all();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("model_clk", 32'(model_clk), 32'(m_clk));
    chk("done", 32'(done), 32'(m_done));
    chk("state", 32'(state), 32'(m_st));
    chk("remaining", 32'(remaining), 32'(m_rem));
    n_chk++;
    if (tick_total !== 32'd0 && tick_total !== m_total) begin
      n_fail++;
      $display("FAIL tick_total: got %0h expected %0h (or 0)", tick_total, m_total);
    end
  endtask

  // Called at a negedge: drive, check ready, clock, check outputs.
  task automatic step(input logic v, input logic [1:0] op,
                      input logic [15:0] n, input logic ab);
    cmd_valid = v;
    cmd_op = op;
    cmd_count = n;
    abort = ab;
    #1;
    rdy_seen = cmd_ready;
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready(ab)));
    @(posedge clk);
    model_edge(v, op, n, ab);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, OP_HALT, 16'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [15:0] n;
    logic        ab;
    logic        rdy;
    logic [1:0]  st;
    logic [15:0] rem;
    logic        dn;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int first;
    int hi;
    int done_at;
    int nt;
    int tk[$];
    int rm[$];
    bit found;

    n_chk = 0;
    n_fail = 0;
    cmd_valid = 0;
    cmd_op = 0;
    cmd_count = 0;
    abort = 0;
    rst_n = 0;

    tbl[0] = '{1'b1, OP_HALT,  16'd0, 1'b0, 1'b1, 2'd0, 16'd0, 1'b0};
    tbl[1] = '{1'b1, OP_RUN,   16'd0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0};
    tbl[2] = '{1'b1, OP_BURST, 16'd0, 1'b0, 1'b1, 2'd0, 16'd0, 1'b1};
    tbl[3] = '{1'b0, OP_HALT,  16'd0, 1'b0, 1'b1, 2'd0, 16'd0, 1'b0};
    tbl[4] = '{1'b1, OP_STEP,  16'd0, 1'b0, 1'b1, 2'd2, 16'd1, 1'b0};
    tbl[5] = '{1'b1, OP_RUN,   16'd0, 1'b1, 1'b0, 2'd3, 16'd0, 1'b0};
    tbl[6] = '{1'b0, OP_HALT,  16'd0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1};
    tbl[7] = '{1'b0, OP_HALT,  16'd0, 1'b0, 1'b1, 2'd0, 16'd0, 1'b0};

    do_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_model_clk", 32'(model_clk), 32'd0);
    chk("rst_tick_total", tick_total, 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].op, tbl[i].n, tbl[i].ab);
      chk("tbl_ready", 32'(rdy_seen), 32'(tbl[i].rdy));
      chk("tbl_state", 32'(state), 32'(tbl[i].st));
      chk("tbl_remaining", 32'(remaining), 32'(tbl[i].rem));
      chk("tbl_done", 32'(done), 32'(tbl[i].dn));
    end

    // STEP: one tick 8 cycles after acceptance, 4 high cycles, then done.
    step(1'b1, OP_STEP, 16'd0, 1'b0);
    first = -1; hi = 0; done_at = -1; nt = 0;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (tick) begin nt++; if (first < 0) first = i; end
      if (model_clk) hi++;
      if (done && done_at < 0) done_at = i;
    end
    chk("step_tick_at", 32'(first), 32'd8);
    chk("step_ticks", 32'(nt), 32'd1);
    chk("step_high", 32'(hi), 32'd4);
    chk("step_done_at", 32'(done_at), 32'd13);
    chk("step_end_state", 32'(state), 32'd0);

    // BURST 3: ticks 8 apart with remaining 2,1,0.
    step(1'b1, OP_BURST, 16'd3, 1'b0);
    done_at = -1;
    for (int i = 1; i <= 50; i++) begin
      idle();
      if (tick) begin tk.push_back(i); rm.push_back(int'(remaining)); end
      if (done && done_at < 0) done_at = i;
    end
    chk("burst_ticks", 32'(tk.size()), 32'd3);
    for (int k = 0; k < tk.size() && k < 3; k++) begin
      chk("burst_tick_at", 32'(tk[k]), 32'(8 * (k + 1)));
      chk("burst_rem", 32'(rm[k]), 32'(2 - k));
    end
    chk("burst_done_at", 32'(done_at), 32'd29);

    // RUN then HALT while model_clk is high.
    step(1'b1, OP_RUN, 16'd0, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle();
      if (model_clk) found = 1;
    end
    chk("halt_found_high", 32'(found), 32'd1);
    hi = 1; nt = 0; done_at = -1;
    step(1'b1, OP_HALT, 16'd0, 1'b0);
    if (model_clk) hi++;
    for (int i = 0; i < 30; i++) begin
      idle();
      if (model_clk) hi++;
      if (tick) nt++;
      if (done && done_at < 0) done_at = i;
    end
    chk("halt_high", 32'(hi), 32'd4);
    chk("halt_no_tick", 32'(nt), 32'd0);
    chk("halt_done_seen", 32'(done_at >= 0), 32'd1);

    // Abort on the edge of the second BURST tick.
    do_reset();
    step(1'b1, OP_BURST, 16'd5, 1'b0);
    for (int i = 1; i < 16; i++) idle();
    step(1'b0, OP_HALT, 16'd0, 1'b1);
    chk("abort_tick", 32'(tick), 32'd1);
    chk("abort_rem", 32'(remaining), 32'd0);
    chk("abort_state", 32'(state), 32'd3);
    done_at = -1;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (done && done_at < 0) done_at = i;
    end
    chk("abort_done_seen", 32'(done_at >= 0), 32'd1);
    n_chk++;
    if (tick_total !== 32'd0 && tick_total !== 32'd2) begin
      n_fail++;
      $display("FAIL abort_tick_total: got %0h expected 2 (or 0)", tick_total);
    end

    // Asynchronous reset while model_clk is high.
    step(1'b1, OP_RUN, 16'd0, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle();
      if (model_clk) found = 1;
    end
    chk("arst_found_high", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_model_clk", 32'(model_clk), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_remaining", 32'(remaining), 32'd0);
    chk("arst_tick_total", tick_total, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) idle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic ab;
      logic [1:0] op;
      logic [15:0] n;
      v = ($urandom_range(0, 99) < 25);
      ab = ($urandom_range(0, 99) < 2);
      op = 2'($urandom_range(0, 3));
      n = 16'($urandom_range(0, 4));
      step(v, op, n, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mimosa_clock_sequencer.md
MIMOSA_CLOCK_SEQUENCER -- requirements
Module: mimosa_clock_sequencer

Interface
REQ-001 SHALL have parameter PRESCALER, default 5208, meaning the number of clk cycles per model clock period (even, >= 4).
REQ-002 SHALL have port clk, input, 1 bit: the 100 MHz system clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 HALT, 01 RUN, 10 STEP, 11 BURST.
REQ-007 SHALL have port cmd_count, input, 16 bits: BURST tick count.
REQ-008 SHALL have port abort, input, 1 bit: forces a graceful stop from any active state.
REQ-009 SHALL have port model_clk, output, 1 bit: gated, divided clock for the model.
REQ-010 SHALL have port tick, output, 1 bit: one-cycle pulse on each model_clk rising edge.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on return to IDLE.
REQ-012 SHALL have port state, output, 2 bits: 00 IDLE, 01 RUN, 10 COUNT, 11 DRAIN.
REQ-013 SHALL have port remaining, output, 16 bits: ticks still owed in COUNT.
REQ-014 SHALL have port tick_total, output, 32 bits: see Configuration.

Function
REQ-015 Phase counter cnt SHALL run 0..PRESCALER-1 only in RUN/COUNT/DRAIN, and SHALL be held at 0 in IDLE.
REQ-016 At cnt==PRESCALER-1, cnt SHALL wrap to 0; model_clk SHALL go to 1 and tick SHALL pulse in the same registered cycle.
REQ-017 At cnt==PRESCALER/2-1, model_clk SHALL go to 0; the high phase is exactly PRESCALER/2 cycles, and the first rising edge comes PRESCALER cycles after command acceptance.
REQ-018 cmd_ready SHALL be 1 in IDLE and RUN and 0 in COUNT/DRAIN, and SHALL be 0 whenever abort=1.
REQ-019 In IDLE: RUN->RUN; STEP->COUNT with remaining=1; BURST with count N>0->COUNT with remaining=N; BURST with count 0 SHALL stay IDLE and pulse done next cycle; HALT SHALL be accepted as a no-op.
REQ-020 In RUN: HALT SHALL be accepted and go to DRAIN; RUN/STEP/BURST SHALL be accepted and ignored.
REQ-021 In COUNT: each tick SHALL decrement remaining, and the tick taking it to 0 SHALL move the state to DRAIN.
REQ-022 abort in RUN/COUNT SHALL move to DRAIN and clear remaining; a tick due in that cycle SHALL still be emitted; abort in IDLE/DRAIN SHALL have no effect.
REQ-023 DRAIN SHALL never truncate a high phase: it holds until model_clk==0, then goes to IDLE, and no new tick occurs in DRAIN.
REQ-024 done SHALL pulse in the first IDLE cycle after DRAIN.

Reset
REQ-025 On rst_n low, the block SHALL immediately set state=IDLE, cnt=0, model_clk=0, tick=0, done=0, remaining=0, tick_total=0.
REQ-026 Reset mid-operation SHALL drop model_clk asynchronously, and no tick or done SHALL follow.

Configuration
REQ-027 With MIMOSA_SEQ_TICK_COUNTER_EN defined, tick_total SHALL count every tick since reset and saturate at 0xFFFFFFFF.
REQ-028 Without MIMOSA_SEQ_TICK_COUNTER_EN, tick_total SHALL be constant 0 and no counter logic SHALL be built.

Verification (PRESCALER=8)
REQ-029 STEP from IDLE -> one tick 8 cycles after acceptance, model_clk high 4 cycles, done pulse, remaining 0, state IDLE.
REQ-030 BURST count=3 -> exactly 3 ticks 8 cycles apart, remaining 3->2->1->0, then DRAIN, IDLE and done.
REQ-031 BURST count=0 -> no tick, done pulse one cycle after acceptance, state stays IDLE.
REQ-032 RUN, then HALT while model_clk=1 -> high phase completes its full 4 cycles, no further tick, done pulse.
REQ-033 abort asserted in the same cycle as the second tick of BURST count=5 -> that tick is emitted, remaining=0, DRAIN, done, tick_total=2 (macro defined).
REQ-034 rst_n pulsed low during RUN with model_clk=1 -> model_clk=0 immediately, all outputs at reset values, no done.
